// File: rtl/toggle_req_gen.sv
// toggle_req_gen
//
// Front end for a T flip-flop. A raw, bouncy push-button level is first
// synchronized and then debounced. Each press that qualifies produces
// exactly one single-cycle T pulse. Holding the button or letting it bounce
// never produces a second pulse for the same press.
//
// Parameters:
//   DEB_CYC    number of consecutive stable synchronized cycles needed to
//              qualify a press or a release (2..65535)
//   CNT_W      width of press_cnt
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   rst        synchronous, active-high reset
//   btn_in     raw asynchronous button level (1 = pressed)
//   en         pulse enable; when 0, the pulse and the count are suppressed
//   T          registered toggle-request pulse, one cycle per qualified press
//   held       registered; 1 while a press is qualified and not yet released
//   press_cnt  number of emitted T pulses, wraps modulo 2^CNT_W
`timescale 1ns/1ps

module toggle_req_gen #(
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             en,
  output logic             T,
  output logic             held,
  output logic [CNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // The debounce counter compares against DEB_CYC-1 because the counter is
  // already 1 on the first cycle spent in a check state.
  localparam logic [15:0]      CNT_LAST  = 16'(DEB_CYC - 1);
  localparam logic [15:0]      CNT_ONE   = 16'd1;
  localparam logic [CNT_W-1:0] PRESS_ONE = CNT_W'(1);

  logic        s1;
  logic        s2;
  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        qualify;
  logic        t_nxt;
  logic        held_nxt;

  // State register, synchronizer, and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      T         <= 1'b0;
      held      <= 1'b0;
      press_cnt <= '0;
    end else begin
      s1    <= btn_in;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      T     <= t_nxt;
      held  <= held_nxt;
      if (t_nxt) begin
        press_cnt <= press_cnt + PRESS_ONE;
      end
    end
  end

  // Next-state logic. Only the synchronized level s2 is looked at, so the
  // raw input never reaches any decision directly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    qualify   = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          qualify   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_nxt = REL_CHK;
          cnt_nxt   = CNT_ONE;
        end
      end
      REL_CHK: begin
        if (s2) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode. A press taken while en is low is still consumed by the
  // FSM; only the pulse and the count are suppressed. held is decoded from
  // the next state so that it rises on the same edge as T.
  always_comb begin
    t_nxt    = qualify & en;
    held_nxt = (state_nxt == PRESSED) || (state_nxt == REL_CHK);
  end

endmodule

// File: tb/tb_toggle_req_gen.sv
`timescale 1ns/1ps

module tb_toggle_req_gen;

  localparam int DEB_CYC = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_in;
  logic             en;
  logic             T;
  logic             held;
  logic [CNT_W-1:0] press_cnt;

  toggle_req_gen #(
    .DEB_CYC (DEB_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .en        (en),
    .T         (T),
    .held      (held),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; after edge k this holds k.
  int edgeCnt = 0;
  always @(posedge clk) edgeCnt++;

  typedef struct {
    int edgeNum;
    int cnt;
  } expPulse_t;

  expPulse_t expQ[$];
  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every T pulse must match the oldest expected pulse,
  // and an expected pulse whose edge has passed unseen is reported missing.
  always @(negedge clk) begin
    expPulse_t e;
    if (T === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got T=1 at edge %0d (press_cnt %0d), expected no pulse",
                 edgeCnt, press_cnt);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_edge", edgeCnt, e.edgeNum);
        checkOutput("pulse_cnt", press_cnt, e.cnt);
      end
    end else if (expQ.size() > 0 && expQ[0].edgeNum < edgeCnt) begin
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_pulse: got no T by edge %0d, expected pulse at edge %0d",
               edgeCnt, e.edgeNum);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic b, input int n);
    btn_in = b;
    waitCycles(n);
  endtask

  // e0 is the first edge that samples the steady high level.
  task automatic expectPulse(input int e0);
    expCnt = (expCnt + 1) % (1 << CNT_W);
    expQ.push_back('{edgeNum: e0 + DEB_CYC + 1, cnt: expCnt});
  endtask

  task automatic resetDut();
    rst    = 1'b1;
    btn_in = 1'b0;
    en     = 1'b1;
    waitCycles(2);
    rst    = 1'b0;
    expCnt = 0;
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: got no completion by 200us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0;
    int l0;

    // Reset values, with the button already held down during reset.
    rst    = 1'b1;
    btn_in = 1'b1;
    en     = 1'b1;
    waitCycles(2);
    checkOutput("rst_T", T, 0);
    checkOutput("rst_held", held, 0);
    checkOutput("rst_cnt", press_cnt, 0);
    rst = 1'b0;
    expectPulse(edgeCnt + 1);
    waitCycles(20);
    checkOutput("t1_cnt", press_cnt, 1);
    applyStimulus(1'b0, 10);
    checkOutput("t1_released", held, 0);

    // Clean press: held rises exactly at E5 along with T.
    resetDut();
    e0 = edgeCnt + 1;
    btn_in = 1'b1;
    expectPulse(e0);
    waitCycles(DEB_CYC + 1);
    checkOutput("t2_held_E4", held, 0);
    checkOutput("t2_T_E4", T, 0);
    waitCycles(1);
    checkOutput("t2_held_E5", held, 1);
    waitCycles(15);
    checkOutput("t2_cnt", press_cnt, 1);
    checkOutput("t2_held", held, 1);
    applyStimulus(1'b0, 10);
    checkOutput("t2_released", held, 0);

    // Press bounce: only the steady high qualifies.
    resetDut();
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 1);
    expectPulse(edgeCnt + 1);
    applyStimulus(1'b1, 20);
    checkOutput("t3_cnt", press_cnt, 1);
    applyStimulus(1'b0, 10);

    // Release bounce: held stays up until 5 edges after the steady low.
    resetDut();
    expectPulse(edgeCnt + 1);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 2);
    checkOutput("t4_held_bounce_lo", held, 1);
    applyStimulus(1'b1, 1);
    checkOutput("t4_held_bounce_hi", held, 1);
    l0 = edgeCnt + 1;
    applyStimulus(1'b0, DEB_CYC + 1);
    checkOutput("t4_held_L4", held, 1);
    waitCycles(1);
    checkOutput("t4_held_L5", held, 0);
    checkOutput("t4_edge", edgeCnt, l0 + DEB_CYC + 1);
    checkOutput("t4_cnt", press_cnt, 1);
    waitCycles(5);

    // Enable low consumes a press without pulsing; then wrap the counter.
    resetDut();
    en = 1'b0;
    applyStimulus(1'b1, 20);
    checkOutput("t5_en0_cnt", press_cnt, 0);
    checkOutput("t5_en0_held", held, 1);
    applyStimulus(1'b0, 10);
    en = 1'b1;
    waitCycles(10);
    checkOutput("t5_no_replay", press_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      expectPulse(edgeCnt + 1);
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, 8);
      if (i == 254) checkOutput("t5_cnt255", press_cnt, 255);
    end
    checkOutput("t5_wrap", press_cnt, 0);

    // Reset at the qualifying edge drops the pulse; the still-held button
    // re-qualifies from scratch afterwards.
    resetDut();
    e0 = edgeCnt + 1;
    btn_in = 1'b1;
    waitCycles(DEB_CYC + 1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("t6_T", T, 0);
    checkOutput("t6_cnt", press_cnt, 0);
    checkOutput("t6_held", held, 0);
    checkOutput("t6_edge", edgeCnt, e0 + DEB_CYC + 1);
    rst = 1'b0;
    expCnt = 0;
    expectPulse(edgeCnt + 1);
    waitCycles(20);
    checkOutput("t6_cnt_after", press_cnt, 1);
    applyStimulus(1'b0, 10);

    waitCycles(5);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
